// File: rtl/elastic_register.sv
// elastic_register: DEPTH-stage valid/ready pipeline with bubble collapsing.
// Each stage advances whenever it is empty or the stage after it advances,
// so throughput is one word per cycle and holes in the pipe are squeezed out
// even while the output is stalled. Outputs come straight from registers,
// except in_ready, which is the combinational head of the advance chain.
module elastic_register #(
  parameter int N     = 1,
  parameter int DEPTH = 1,
  localparam int CW   = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  // Stage state; index 0 faces the input, index DEPTH-1 drives the output.
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [N-1:0]     d [DEPTH];

  // move[i]: stage i takes its upstream value at the next edge.
  // The chain's top term, move[DEPTH], is out_ready itself.
  logic [DEPTH-1:0] move;

  // Number of set bits in a stage-valid vector.
  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] x);
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      acc = acc + CW'(x[i]);
    end
    return acc;
  endfunction

  // Advance chain: move[i] = !v[i] | move[i+1] with move[DEPTH] = out_ready,
  // unrolled as "out_ready, or some stage at or after i is empty" so no
  // vector bit feeds back into its own vector.
  always_comb begin
    logic full_suffix;
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    move        = '0;
    full_suffix = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      full_suffix = full_suffix & v[i];
      move[i]     = out_ready | !full_suffix;
    end
  end

  // Next valid bits: a moving stage takes its upstream valid, a stalled one holds.
  always_comb begin
    v_next    = v;
    if (move[0]) begin
      v_next[0] = in_valid;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (move[i]) begin
        v_next[i] = v[i-1];
      end
    end
  end

  // Valid bits and occupancy count; reset wins over any transfer in that cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      v     <= '0;
      count <= '0;
    end else begin
      v     <= v_next;
      count <= popcount(v_next);
    end
  end

  // Data words load only when the stage moves and its source is valid, so an
  // empty pipe keeps a stable out_data and a stalled word never changes.
  always_ff @(posedge clk) begin
    // NOTE: the data stages are cleared on reset too, so out_data reads zero right after reset.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else begin
      if (move[0] && in_valid) begin
        d[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (move[i] && v[i-1]) begin
          d[i] <= d[i-1];
        end
      end
    end
  end

  assign in_ready  = move[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: doc/elastic_register.md
ELASTIC_REGISTER -- requirements
Module: elastic_register

Interface
REQ-001 Parameter N, default 1: data width in bits, N >= 1.
REQ-002 Parameter DEPTH, default 1: number of register stages, DEPTH >= 1.
REQ-003 Derived width CW = ceil(log2(DEPTH+1)), with a minimum of 1.
REQ-004 clk  input  1: the single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 in_valid  input  1: upstream offers in_data this cycle.
REQ-007 in_data  input  N: upstream data word.
REQ-008 in_ready  output  1: the block accepts in_data this cycle.
REQ-009 out_valid  output  1: out_data is valid this cycle.
REQ-010 out_data  output  N: data word from the last stage.
REQ-011 out_ready  input  1: downstream accepts out_data this cycle.
REQ-012 count  output  CW: number of stages currently holding valid data.

Function
REQ-013 Each stage i (0..DEPTH-1) SHALL hold a valid bit v[i] and a data word d[i]; stage 0 is the input side.
REQ-014 move[DEPTH] SHALL equal out_ready; move[i] SHALL equal !v[i] OR move[i+1]; all move signals are combinational.
REQ-015 in_ready SHALL equal move[0] and SHALL be combinational from out_ready and the stage valid bits only, never from in_valid.
REQ-016 When move[i] is 1 at a clock edge, stage 0 SHALL load v[0] <= in_valid, and stage i>0 SHALL load v[i] <= v[i-1].
REQ-017 d[i] SHALL load from its source (in_data or d[i-1]) only when move[i] is 1 and the source valid bit is 1; otherwise d[i] SHALL hold its value.
REQ-018 When move[i] is 0, v[i] and d[i] SHALL hold their values (stall).
REQ-019 out_valid SHALL be v[DEPTH-1] and out_data SHALL be d[DEPTH-1], both driven directly from registers.
REQ-020 A transfer occurs on a port when valid and ready are both 1 at a clock edge; any other cycle transfers nothing.
REQ-021 Latency SHALL be exactly DEPTH cycles from input transfer to out_valid when there is no stall.
REQ-022 Throughput SHALL be one word per cycle; when all stages are full and out_ready=1, in_ready SHALL be 1, and input and output SHALL transfer in the same cycle.
REQ-023 Bubbles (stages with v=0) SHALL collapse: a stage with a bubble SHALL accept from upstream even while downstream is stalled.
REQ-024 Order SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-025 count SHALL equal the popcount of v[] and SHALL be registered, updating in the same edge as the valid bits.
REQ-026 When all stages are full and out_ready=0, in_ready SHALL be 0, and in_data SHALL be ignored regardless of in_valid.
REQ-027 Empty state (count=0) SHALL give out_valid=0; out_data is don't-care but stable.
REQ-028 When DEPTH=1, the block SHALL behave as a single-entry register slice, with in_ready = !v[0] | out_ready.
REQ-029 Once out_valid=1, out_data SHALL NOT change until an output transfer occurs.

Reset
REQ-030 When rst=1 at a clock edge, all v[i] <= 0, all d[i] <= 0, and count <= 0, overriding any transfer in that cycle.
REQ-031 A word presented while rst=1 SHALL be discarded, even if in_ready=1 in that cycle.
REQ-032 In the first cycle after reset release: out_valid=0, out_data=0, count=0, in_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all held words; no partial output SHALL appear afterwards.

Verification
REQ-034 Streaming, N=8, DEPTH=3, out_ready=1: input 0x01,0x02,0x03 on consecutive cycles -> out_valid=1 with 0x01,0x02,0x03 on cycles 3,4,5; count peaks at 3; in_ready stays 1 throughout.
REQ-035 Fill under stall, out_ready=0: input 0xA0..0xA4 -> only 0xA0..0xA2 accepted, in_ready=0 from cycle 3 on, count=3, out_data=0xA0 held stable.
REQ-036 Full-pass, full pipe with out_ready=1 and in_valid=1: one word in and one word out per cycle, count stays 3, order preserved.
REQ-037 Bubble collapse: input 0x11, idle 1 cycle, input 0x22, with out_ready=0 from cycle 2 -> both words packed into stages 2 and 1, count=2, in_ready=1.
REQ-038 Reset mid-operation: count=2, then rst=1 for 1 cycle with in_valid=1 and data 0x55 -> next cycle count=0, out_valid=0, out_data=0, and 0x55 never appears at the output.
REQ-039 DEPTH=1, N=16: alternate out_ready 1/0 under continuous input -> no loss or duplication, checked against a reference queue.
